// File: rtl/mac_drain_pkg.sv
// mac_drain_pkg: shared FSM state type and beat-counter sizing for the result drain
package mac_drain_pkg;
  typedef enum logic {ST_ACCUM, ST_DRAIN} drain_state_t;
  function automatic int beat_w(input int num, input int lanes);
    return (num / lanes > 1) ? $clog2(num / lanes) : 1;
  endfunction
endpackage

// File: rtl/mac_drain_lane_sel.sv
// mac_drain_lane_sel: picks the LANES words of one output beat from the buffer
// Ports: data (whole buffer, word 0 in LSBs), beat (beat index), lanes (selected words, lane 0 in LSBs)
// Build option: DRAIN_RELU_EN clamps negative lanes to zero on the way out
module mac_drain_lane_sel
  import mac_drain_pkg::*;
#(
  parameter int OUT_BIT = 32,
  parameter int NUM = 256,
  parameter int LANES = 8,
  parameter int BW = beat_w(NUM, LANES)
) (
  input  logic [NUM-1:0][OUT_BIT-1:0]   data,
  input  logic [BW-1:0]                 beat,
  output logic [LANES-1:0][OUT_BIT-1:0] lanes
);
  localparam int BEATS = NUM / LANES;
  logic [BEATS-1:0][LANES-1:0][OUT_BIT-1:0] grp;
  assign grp = data;
  for (genvar j = 0; j < LANES; j++) begin : g_lane
`ifdef DRAIN_RELU_EN
    assign lanes[j] = grp[beat][j][OUT_BIT-1] ? '0 : grp[beat][j];
`else
    assign lanes[j] = grp[beat][j];
`endif
  end
endmodule

// File: rtl/mac_result_drain.sv
// mac_result_drain: accumulates array tiles in a buffer and streams it out as valid/ready beats
// Ports: clk, reset (sync, active-low); tile_valid/tile_ready/tile_first/tile_last/array_out (tile in);
//        acc_o (accumulator operand back to array); m_valid/m_ready/m_data/m_last (beat stream); busy
// Build option: DRAIN_RELU_EN applies ReLU to m_data lanes only
module mac_result_drain
  import mac_drain_pkg::*;
#(
  parameter int OUT_BIT = 32,
  parameter int MAC_R = 32,
  parameter int MAC_C = 8,
  parameter int LANES = 8,
  localparam int NUM = MAC_R * MAC_C,
  localparam int BEATS = NUM / LANES,
  localparam int BW = beat_w(NUM, LANES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tile_valid,
  output logic                        tile_ready,
  input  logic                        tile_first,
  input  logic                        tile_last,
  input  logic [NUM-1:0][OUT_BIT-1:0] array_out,
  output logic [NUM-1:0][OUT_BIT-1:0] acc_o,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [LANES*OUT_BIT-1:0]    m_data,
  output logic                        m_last,
  output logic                        busy
);
  drain_state_t state, state_nx;
  logic [NUM-1:0][OUT_BIT-1:0] acc_buf;
  logic [BW-1:0] beat;
  logic partial, accept, hs, fin;
  logic [LANES-1:0][OUT_BIT-1:0] sel;
  mac_drain_lane_sel #(.OUT_BIT(OUT_BIT), .NUM(NUM), .LANES(LANES), .BW(BW)) u_sel (
    .data (acc_buf),
    .beat (beat),
    .lanes(sel)
  );
  // every output is forced quiet while reset is held low
  always_comb begin
    state_nx = state;
    tile_ready = reset && state == ST_ACCUM;
    m_valid = reset && state == ST_DRAIN;
    m_last = m_valid && beat == BW'(BEATS - 1);
    busy = reset && (state == ST_DRAIN || partial);
    accept = tile_valid && tile_ready;
    hs = m_valid && m_ready;
    fin = hs && m_last;
    if (accept && tile_last) state_nx = ST_DRAIN;
    if (fin) state_nx = ST_ACCUM;
  end
  assign acc_o = (!reset || tile_first) ? '0 : acc_buf;
  assign m_data = m_valid ? sel : '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_ACCUM;
      acc_buf <= '0;
      beat <= '0;
      partial <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) acc_buf <= array_out;
      if (accept) partial <= !tile_last;
      else if (fin) partial <= 1'b0;
      if (accept) beat <= '0;
      else if (hs) beat <= beat + 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_result_drain.sv
// tb_mac_result_drain: randomized self-checking bench against a buffer-level reference model
module tb_mac_result_drain;
  localparam int NUM = 256;
  localparam int LANES = 8;
  localparam int BEATS = NUM / LANES;
  logic clk = 1'b0;
  logic reset, tile_valid, tile_ready, tile_first, tile_last;
  logic [NUM-1:0][31:0] array_out, acc_o;
  logic m_valid, m_ready, m_last, busy;
  logic [LANES*32-1:0] m_data;
  int checks = 0, failures = 0;
  logic [31:0] mbuf [NUM];
  logic [31:0] add_v [NUM];
  logic [255:0] obs_data [$];
  bit obs_last [$];
  int obs_tr;
  mac_result_drain dut (
    .clk(clk), .reset(reset), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_first(tile_first), .tile_last(tile_last), .array_out(array_out), .acc_o(acc_o),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  function automatic logic [255:0] exp_beat(input int b);
    logic [255:0] r;
    logic [31:0] w;
    r = '0;
    for (int j = 0; j < LANES; j++) begin
      w = mbuf[b*LANES+j];
`ifdef DRAIN_RELU_EN
      if (w[31]) w = '0;
`endif
      r[j*32+:32] = w;
    end
    return r;
  endfunction
  // array model: it returns acc operand plus a product term (add_v)
  task automatic send_tile(input bit first, input bit last, output int acc_bad, output bit to);
    logic [31:0] a;
    @(negedge clk);
    tile_first = first;
    tile_last = last;
    tile_valid = 1'b1;
    #1;
    acc_bad = 0;
    for (int i = 0; i < NUM; i++) begin
      a = first ? 32'd0 : mbuf[i];
      if (acc_o[i] !== a) acc_bad++;
      array_out[i] = a + add_v[i];
    end
    to = 1'b1;
    for (int n = 0; n < 500; n++) begin
      if (tile_ready === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!to) begin
      @(posedge clk);
      for (int i = 0; i < NUM; i++) mbuf[i] = array_out[i];
    end
    @(negedge clk);
    tile_valid = 1'b0;
    tile_first = 1'b0;
    tile_last = 1'b0;
  endtask
  task automatic collect_drain(input bit rnd, output bit to);
    obs_data.delete();
    obs_last.delete();
    obs_tr = 0;
    to = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (m_valid && tile_ready) obs_tr++;
      if (m_valid && m_ready) begin
        obs_data.push_back(m_data);
        obs_last.push_back(m_last);
        if (m_last) begin
          to = 1'b0;
          break;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    tile_valid = 1'b0;
    tile_first = 1'b0;
    tile_last = 1'b0;
    m_ready = 1'b0;
    array_out = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({tile_ready, m_valid, m_last, busy} !== 4'b0 || acc_o !== '0 || m_data !== '0) begin
      failures++;
      $display("FAIL reset_hold got tr/mv/ml/busy=%b exp=0000", {tile_ready, m_valid, m_last, busy});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NUM; i++) mbuf[i] = '0;
    @(negedge clk);
    #1;
    checks++;
    if ({tile_ready, m_valid, m_last, busy} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_release got tr/mv/ml/busy=%b exp=1000", {tile_ready, m_valid, m_last, busy});
    end
  endtask
  task automatic test_single;
    int acc_bad, bad;
    bit to;
    for (int i = 0; i < NUM; i++) add_v[i] = i;
    send_tile(1'b1, 1'b1, acc_bad, to);
    checks++;
    if (to || acc_bad != 0) begin
      failures++;
      $display("FAIL single_acc got bad=%0d to=%0d exp=0", acc_bad, to);
    end
    #1;
    checks++;
    if (m_valid !== 1'b1 || tile_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_latency got mv=%b tr=%b exp mv=1 tr=0", m_valid, tile_ready);
    end
    collect_drain(1'b0, to);
    bad = 0;
    for (int b = 0; b < obs_data.size(); b++)
      if (obs_data[b] !== exp_beat(b) || obs_last[b] !== (b == BEATS - 1)) bad++;
    checks++;
    if (to || obs_data.size() != BEATS || bad != 0) begin
      failures++;
      $display("FAIL single_drain got beats=%0d bad=%0d exp beats=%0d bad=0", obs_data.size(), bad, BEATS);
    end
    checks++;
    if (obs_data.size() != BEATS || obs_data[0][31:0] !== 32'd0 || obs_data[0][255:224] !== 32'd7 ||
        obs_data[BEATS-1][31:0] !== 32'd248 || obs_data[BEATS-1][255:224] !== 32'd255) begin
      failures++;
      $display("FAIL single_ends got beats=%0d exp first={7..0} last={255..248}", obs_data.size());
    end
    checks++;
    if ({tile_ready, m_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL single_after got tr/mv/busy=%b exp=100", {tile_ready, m_valid, busy});
    end
  endtask
  task automatic test_multi;
    int acc_bad, bad, tot_bad;
    bit to;
    for (int i = 0; i < NUM; i++) add_v[i] = $urandom;
    send_tile(1'b1, 1'b0, acc_bad, to);
    for (int i = 0; i < NUM; i++) add_v[i] = 32'd5;
    tot_bad = 0;
    send_tile(1'b1, 1'b0, acc_bad, to);
    tot_bad += acc_bad + int'(to);
    #1;
    checks++;
    if ({busy, m_valid, tile_ready} !== 3'b101) begin
      failures++;
      $display("FAIL multi_partial got busy/mv/tr=%b exp=101", {busy, m_valid, tile_ready});
    end
    send_tile(1'b0, 1'b0, acc_bad, to);
    tot_bad += acc_bad + int'(to);
    send_tile(1'b0, 1'b1, acc_bad, to);
    tot_bad += acc_bad + int'(to);
    checks++;
    if (tot_bad != 0) begin
      failures++;
      $display("FAIL multi_acc got bad=%0d exp=0", tot_bad);
    end
    collect_drain(1'b1, to);
    bad = 0;
    for (int b = 0; b < obs_data.size(); b++)
      for (int j = 0; j < LANES; j++)
        if (obs_data[b][j*32+:32] !== 32'd15) bad++;
    checks++;
    if (to || obs_data.size() != BEATS || bad != 0) begin
      failures++;
      $display("FAIL multi_drain got beats=%0d bad_words=%0d exp beats=%0d all 15", obs_data.size(), bad, BEATS);
    end
  endtask
  task automatic test_backpressure;
    int acc_bad, hold_bad, order_bad, nb;
    bit to, pv, pr, done;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [255:0] pd;
    logic [31:0] nxt [NUM];
    for (int i = 0; i < NUM; i++) add_v[i] = $urandom;
    send_tile(1'b1, 1'b1, acc_bad, to);
    tile_valid = 1'b1;
    tile_first = 1'b1;
    tile_last = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      nxt[i] = $urandom;
      array_out[i] = nxt[i];
    end
    hold_bad = 0;
    order_bad = 0;
    obs_tr = 0;
    nb = 0;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      m_ready = pat[n%4];
      #1;
      if (tile_ready) obs_tr++;
      if (pv && !pr && m_data !== pd) hold_bad++;
      if (m_valid && m_ready) begin
        if (m_data !== exp_beat(nb) || m_last !== (nb == BEATS - 1)) order_bad++;
        if (m_last) done = 1'b1;
        nb++;
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
      @(negedge clk);
    end
    m_ready = 1'b0;
    checks++;
    if (!done || nb != BEATS || order_bad != 0 || hold_bad != 0) begin
      failures++;
      $display("FAIL bp_drain got beats=%0d order_bad=%0d hold_bad=%0d exp beats=%0d", nb, order_bad, hold_bad, BEATS);
    end
    checks++;
    if (obs_tr != 0) begin
      failures++;
      $display("FAIL bp_tile_ready got cycles_ready=%0d exp=0", obs_tr);
    end
    #1;
    checks++;
    if (tile_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_after got tr=%b exp=1", tile_ready);
    end
    @(posedge clk);
    for (int i = 0; i < NUM; i++) mbuf[i] = nxt[i];
    @(negedge clk);
    tile_valid = 1'b0;
    tile_first = 1'b0;
    #1;
    checks++;
    if ({busy, m_valid} !== 2'b10) begin
      failures++;
      $display("FAIL bp_held_tile got busy/mv=%b exp=10", {busy, m_valid});
    end
  endtask
  task automatic test_wrap;
    int acc_bad, bad;
    bit to;
    for (int i = 0; i < NUM; i++) add_v[i] = 32'hFFFF_FFFF;
    send_tile(1'b1, 1'b0, acc_bad, to);
    for (int i = 0; i < NUM; i++) add_v[i] = 32'd2;
    send_tile(1'b0, 1'b1, acc_bad, to);
    checks++;
    if (to || acc_bad != 0) begin
      failures++;
      $display("FAIL wrap_acc got bad=%0d exp=0", acc_bad);
    end
    collect_drain(1'b1, to);
    bad = 0;
    for (int b = 0; b < obs_data.size(); b++)
      for (int j = 0; j < LANES; j++)
        if (obs_data[b][j*32+:32] !== 32'h0000_0001) bad++;
    checks++;
    if (to || obs_data.size() != BEATS || bad != 0) begin
      failures++;
      $display("FAIL wrap_drain got beats=%0d bad_words=%0d exp all 00000001", obs_data.size(), bad);
    end
  endtask
  task automatic test_reset_mid;
    int acc_bad, bad;
    bit to;
    for (int i = 0; i < NUM; i++) add_v[i] = $urandom;
    send_tile(1'b1, 1'b1, acc_bad, to);
    m_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_last !== 1'b0 || m_data !== exp_beat(10)) begin
      failures++;
      $display("FAIL rst_mid_beat10 got mv=%b data=%h exp=%h", m_valid, m_data, exp_beat(10));
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({tile_ready, m_valid, m_last, busy} !== 4'b0 || acc_o !== '0 || m_data !== '0) begin
      failures++;
      $display("FAIL rst_mid_low got tr/mv/ml/busy=%b exp=0000", {tile_ready, m_valid, m_last, busy});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NUM; i++) mbuf[i] = '0;
    @(negedge clk);
    #1;
    checks++;
    if ({tile_ready, m_valid, busy} !== 3'b100 || acc_o !== '0) begin
      failures++;
      $display("FAIL rst_mid_clear got tr/mv/busy=%b exp=100 with acc_o zero", {tile_ready, m_valid, busy});
    end
    for (int i = 0; i < NUM; i++) add_v[i] = $urandom;
    send_tile(1'b1, 1'b1, acc_bad, to);
    collect_drain(1'b0, to);
    bad = 0;
    for (int b = 0; b < obs_data.size(); b++)
      if (obs_data[b] !== exp_beat(b) || obs_last[b] !== (b == BEATS - 1)) bad++;
    checks++;
    if (to || obs_data.size() != BEATS || bad != 0) begin
      failures++;
      $display("FAIL rst_mid_newjob got beats=%0d bad=%0d exp beats=%0d bad=0", obs_data.size(), bad, BEATS);
    end
  endtask
  task automatic test_relu;
    int acc_bad, bad;
    bit to;
    logic [31:0] e;
    for (int i = 0; i < NUM; i++) add_v[i] = (i % 2 == 0) ? -32'sd3 : 32'sd7;
    send_tile(1'b1, 1'b1, acc_bad, to);
    collect_drain(1'b0, to);
    bad = 0;
    for (int b = 0; b < obs_data.size(); b++)
      for (int j = 0; j < LANES; j++) begin
`ifdef DRAIN_RELU_EN
        e = (j % 2 == 0) ? 32'd0 : 32'd7;
`else
        e = (j % 2 == 0) ? 32'hFFFF_FFFD : 32'd7;
`endif
        if (obs_data[b][j*32+:32] !== e) bad++;
      end
    checks++;
    if (to || obs_data.size() != BEATS || bad != 0) begin
      failures++;
      $display("FAIL relu_drain got beats=%0d bad_words=%0d exp beats=%0d", obs_data.size(), bad, BEATS);
    end
    for (int i = 0; i < NUM; i++) add_v[i] = 32'd0;
    send_tile(1'b0, 1'b1, acc_bad, to);
    checks++;
    if (to || acc_bad != 0 || mbuf[0] !== 32'hFFFF_FFFD || mbuf[1] !== 32'd7) begin
      failures++;
      $display("FAIL relu_readback got bad=%0d exp=0 (raw -3/+7)", acc_bad);
    end
    collect_drain(1'b1, to);
    bad = 0;
    for (int b = 0; b < obs_data.size(); b++)
      if (obs_data[b] !== exp_beat(b)) bad++;
    checks++;
    if (to || obs_data.size() != BEATS || bad != 0) begin
      failures++;
      $display("FAIL relu_redrain got beats=%0d bad=%0d exp beats=%0d bad=0", obs_data.size(), bad, BEATS);
    end
  endtask
  task automatic test_random;
    int acc_bad, bad, nt;
    bit to;
    for (int job = 0; job < 4; job++) begin
      nt = $urandom_range(1, 3);
      bad = 0;
      for (int t = 0; t < nt; t++) begin
        for (int i = 0; i < NUM; i++) add_v[i] = $urandom;
        send_tile(t == 0, t == nt - 1, acc_bad, to);
        bad += acc_bad + int'(to);
      end
      collect_drain(1'b1, to);
      for (int b = 0; b < obs_data.size(); b++)
        if (obs_data[b] !== exp_beat(b) || obs_last[b] !== (b == BEATS - 1)) bad++;
      checks++;
      if (to || obs_data.size() != BEATS || bad != 0 || obs_tr != 0) begin
        failures++;
        $display("FAIL random_job%0d got beats=%0d bad=%0d tr_cycles=%0d exp beats=%0d", job, obs_data.size(), bad, obs_tr, BEATS);
      end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_multi;
    test_backpressure;
    test_wrap;
    test_reset_mid;
    test_relu;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
